// File: rtl/blib_pkg.sv
// Shared types for the blib front end: beat payload, arbiter state encoding
// and a small modulo helper for round-robin pointers.
package blib_pkg;

  localparam int MaxNumReq = 16;
  localparam int LalaWidth = 8;

  typedef logic [LalaWidth-1:0] lala;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/blib_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping modulo NumReq.
module rr_pick #(
  parameter int NumReq = 4,
  localparam int IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   req_valid,
  input  logic [IdxWidth-1:0] rr_ptr,
  output logic [IdxWidth-1:0] gnt_idx,
  output logic                gnt_valid
);

  localparam int SumW = IdxWidth + 1;

  logic [SumW-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to rr_ptr wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr} + SumW'(off);
      if (cand >= SumW'(NumReq)) begin
        cand = cand - SumW'(NumReq);
      end
      if (req_valid[cand[IdxWidth-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IdxWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/blib_rr_arbiter.sv
// Round-robin burst arbiter in front of blib: one grant per burst, one
// registered output stage.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ARB_IDLE   | no burst open; winner picked round-robin from rr_ptr
// ARB_LOCKED | burst open on lock_idx; only lock_idx may transfer until last
module blib_rr_arbiter
  import blib_pkg::*;
#(
  parameter int NumReq = 4,
  localparam int IdxWidth = $clog2(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  lala  [NumReq-1:0]   req_data_i,
  input  logic [NumReq-1:0]   req_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output lala                 out_data_o,
  output logic                out_last_o,
  output logic [IdxWidth-1:0] out_idx_o
);

  if (NumReq < 2 || NumReq > MaxNumReq) begin : g_bad_numreq
    $error("blib_rr_arbiter: NumReq out of range");
  end

  arb_state_e          state_q, state_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] pick_idx;
  logic                pick_valid;
  logic [IdxWidth-1:0] gnt_idx;
  logic                gnt_active;
  logic                stage_free;
  logic                xfer;
  logic                xfer_last;
  lala                 xfer_data;

  function automatic logic [IdxWidth-1:0] ptr_after(input logic [IdxWidth-1:0] idx);
    return IdxWidth'(wrap_inc(32'(idx), NumReq));
  endfunction

  rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .req_valid (req_valid_i),
    .rr_ptr    (rr_ptr_q),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  // While locked the picker result is ignored, even if lock_idx is idle.
  always_comb begin
    stage_free = !out_valid_o || out_ready_i;
    if (state_q == ARB_LOCKED) begin
      gnt_idx    = lock_idx_q;
      gnt_active = req_valid_i[lock_idx_q];
    end else begin
      gnt_idx    = pick_idx;
      gnt_active = pick_valid;
    end
    xfer      = stage_free && gnt_active;
    xfer_last = req_last_i[gnt_idx];
    xfer_data = req_data_i[gnt_idx];
    req_ready_o = '0;
    if (xfer) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          if (xfer_last) begin
            rr_ptr_d = ptr_after(gnt_idx);
          end else begin
            state_d    = ARB_LOCKED;
            lock_idx_d = gnt_idx;
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer && xfer_last) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = ptr_after(lock_idx_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // A held beat is discarded on reset rather than replayed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_idx_o   <= '0;
    end else if (xfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= xfer_data;
      out_last_o  <= xfer_last;
      out_idx_o   <= gnt_idx;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=>
      (out_valid_o && $stable(out_data_o) && $stable(out_last_o) && $stable(out_idx_o)));

endmodule
